// File: rtl/sha_pkg.sv
// Shared definitions for the SHA datapath helpers: FSM state encoding,
// word width and the per-operation digit count.
package sha_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of BUSY cycles needed to walk a full word DIGIT_W bits at a time.
    function automatic int unsigned digit_count(input int unsigned digit_w);
        return WORD_W / digit_w;
    endfunction

endpackage

// File: rtl/sub_slice.sv
// Combinational DIGIT_W-bit subtractor with borrow in and borrow out.
module sub_slice #(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] diff,
    output logic               borrow_out
);

    logic [DIGIT_W:0] full;

    // One extra bit catches the borrow: it goes high whenever a < b + borrow_in.
    always_comb begin
        full       = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, borrow_in};
        diff       = full[DIGIT_W-1:0];
        borrow_out = full[DIGIT_W];
    end

endmodule

// File: rtl/sub_serial.sv
// Digit-serial 32-bit subtractor D = A - B with borrow, valid/ready handshake.
// Optional macro SUB_SERIAL_SATURATE_EN clamps D to zero when the result borrows.
module sub_serial
    import sha_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             borrow
);

    localparam int unsigned DIGITS = digit_count(DIGIT_W);
    localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   d_q;
    logic               chain;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT_W-1:0] slice_d;
    logic               slice_b;
    logic               accept;
    logic               last_digit;

    sub_slice #(
        .DIGIT_W (DIGIT_W)
    ) u_slice (
        .a          (a_sh[DIGIT_W-1:0]),
        .b          (b_sh[DIGIT_W-1:0]),
        .borrow_in  (chain),
        .diff       (slice_d),
        .borrow_out (slice_b)
    );

    assign accept     = (state == IDLE) && in_valid;
    assign last_digit = (state == BUSY) && (cnt == LAST_DIGIT);

    // Partial result fills from the MSB side so the LSB slice lands at bit 0 last.
    assign acc_next = (acc >> DIGIT_W) | (WIDTH'(slice_d) << (WIDTH - DIGIT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_digit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The working accumulator is separate from D so D stays frozen between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            chain    <= 1'b0;
            cnt      <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            a_sh  <= A;
            b_sh  <= B;
            acc   <= '0;
            chain <= 1'b0;
            cnt   <= '0;
        end else if (state == BUSY) begin
            a_sh  <= a_sh >> DIGIT_W;
            b_sh  <= b_sh >> DIGIT_W;
            acc   <= acc_next;
            chain <= slice_b;
            cnt   <= cnt + 1'b1;
            if (last_digit) begin
                borrow_q <= slice_b;
`ifdef SUB_SERIAL_SATURATE_EN
                d_q      <= slice_b ? '0 : acc_next;
`else
                d_q      <= acc_next;
`endif
            end
        end
    end

    assign D      = d_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_sub_serial.sv
// Directed self-checking bench for sub_serial at the default DIGIT_W=4.
module tb_sub_serial;

`ifdef SUB_SERIAL_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int LATENCY = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] D;
    logic        borrow;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_d = '0;

    always #5 clk = ~clk;

    sub_serial #(
        .DIGIT_W (4),
        .WIDTH   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .borrow    (borrow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic exp_b,
                           input int hold, input bit poke);
        int n;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A        = $urandom;
        B        = $urandom;
        n        = 0;
        while (!out_valid && n < 20) begin
            if (n == 3) begin
                check({tag, "_d_hold_busy"}, D, last_d);
                if (poke) begin
                    in_valid = 1'b1;
                    A        = 32'h11111111;
                    B        = 32'h00000000;
                end
            end
            if (n == 5 && poke) begin
                check({tag, "_busy_in_ready"}, 32'(in_ready), 32'd0);
                in_valid = 1'b0;
            end
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(LATENCY));
        check({tag, "_d"}, D, exp_d);
        check({tag, "_borrow"}, 32'(borrow), 32'(exp_b));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_stall_d"}, D, exp_d);
            check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_stall_out_valid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_d_after_done"}, D, exp_d);
        last_d = exp_d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] vd [3];
        logic        vbr [3];
        int          got;
        int          cyc;
        int          last_cyc;
        bit          seen;

        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        A         = 32'h12345678;
        B         = 32'h00000001;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d", D, 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        run_txn("sub_basic", 32'h0000000A, 32'h00000003, 32'h00000007, 1'b0, 0, 1'b0);
        run_txn("sub_wrap", 32'h00000000, 32'h00000001, SAT ? 32'h0 : 32'hFFFFFFFF, 1'b1, 0, 1'b0);
        run_txn("sub_equal", 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 1'b0, 5, 1'b0);
        run_txn("sub_poke", 32'h12345678, 32'h02345678, 32'h10000000, 1'b0, 0, 1'b1);
        run_txn("sub_big_b", 32'h00000005, 32'hFFFFFFFF, SAT ? 32'h0 : 32'h00000006, 1'b1, 0, 1'b0);
        run_txn("sub_max", 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 0, 1'b0);
        run_txn("sub_chain", 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1, 1'b0);

        // Abort in the 4th BUSY cycle.
        A        = 32'hFFFFFFFF;
        B        = 32'h00000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_d", D, 32'd0);
        check("abort_borrow", 32'(borrow), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        last_d = 32'd0;
        run_txn("sub_after_abort", 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        va[0] = 32'h00000010; vb[0] = 32'h00000001; vd[0] = 32'h0000000F; vbr[0] = 1'b0;
        va[1] = 32'h00000001; vb[1] = 32'h00000002; vd[1] = SAT ? 32'h0 : 32'hFFFFFFFF; vbr[1] = 1'b1;
        va[2] = 32'hCAFEBABE; vb[2] = 32'h0BADF00D; vd[2] = 32'hBF50CAB1; vbr[2] = 1'b0;
        got       = 0;
        cyc       = 0;
        last_cyc  = 0;
        A         = va[0];
        B         = vb[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (got < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (out_valid) begin
                check($sformatf("b2b_d%0d", got), D, vd[got]);
                check($sformatf("b2b_borrow%0d", got), 32'(borrow), 32'(vbr[got]));
                if (got > 0) begin
                    check($sformatf("b2b_interval%0d", got), 32'(cyc - last_cyc), 32'd10);
                end
                last_cyc = cyc;
                got++;
                if (got < 3) begin
                    A = va[got];
                    B = vb[got];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("b2b_count", 32'(got), 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("b2b_no_extra", 32'(seen), 32'd0);
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
